// File: rtl/uart_rx_frame_timer.sv
// uart_rx_frame_timer
// Oversampling bit/frame timer for the UART receive path. It counts clock edges
// within each bit and bits within each frame. It produces bit-centre sample
// strobes, bit-done pulses and frame-done pulses for the RX FSM and the data
// sampler.
//
// Build option:
//   UART_RX_TRIPLE_SAMPLE_EN  defined   -> three sample strobes per bit at
//                                          M-1, M, M+1, with SAMPLE_LAST at M+1
//                                          (majority vote)
//                             undefined -> one sample strobe per bit at M,
//                                          with SAMPLE_LAST on the same edge
//   Here M = P >> 1, the mid-bit edge index.
//
// State table
//   state | meaning
//   IDLE  | waiting for ENABLE; counters held at 0
//   RUN   | counting edges/bits of a frame; strobes active
//   DONE  | frame finished; parked until ENABLE drops (no runaway re-count)

module uart_rx_frame_timer #(
   parameter int EDGE_W = 6,
   parameter int BIT_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENABLE,
   input  logic [EDGE_W-1:0] PRESCALE,
   input  logic [BIT_W-1:0]  FRAME_BITS,
   output logic [EDGE_W-1:0] EDGE_CNT,
   output logic [BIT_W-1:0]  BIT_CNT,
   output logic              SAMPLE_STB,
   output logic              SAMPLE_LAST,
   output logic              BIT_DONE,
   output logic              FRAME_DONE,
   output logic              BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [EDGE_W-1:0] P_MIN   = EDGE_W'(4);
   localparam logic [BIT_W-1:0]  F_MIN   = BIT_W'(2);
   localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);
   localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

   state_t            state;
   logic [EDGE_W-1:0] edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [EDGE_W-1:0] p_reg;
   logic [BIT_W-1:0]  f_reg;

   logic [EDGE_W-1:0] p_clamped;
   logic [BIT_W-1:0]  f_clamped;
   logic [EDGE_W-1:0] p_last;
   logic [BIT_W-1:0]  f_last;
   logic [EDGE_W-1:0] mid;
   logic              edge_last;
   logic              bit_last;
   logic              in_run;
   logic              hit_sample;
   logic              hit_last_sample;

   // Clamp the runtime inputs so that P-1 and M-1 can never underflow.
   always_comb begin
      p_clamped = (PRESCALE < P_MIN) ? P_MIN : PRESCALE;
      f_clamped = (FRAME_BITS < F_MIN) ? F_MIN : FRAME_BITS;
   end

   // Terminal-count compares use only the values captured at frame start.
   always_comb begin
      p_last    = p_reg - EDGE_ONE;
      f_last    = f_reg - BIT_ONE;
      mid       = p_reg >> 1;
      edge_last = (edge_cnt == p_last);
      bit_last  = (bit_cnt == f_last);
      in_run    = (state == ST_RUN);
   end

   // Decode the sample set from the edge counter.
   // Nothing here depends on the module inputs.
`ifdef UART_RX_TRIPLE_SAMPLE_EN
   always_comb begin
      hit_sample      = (edge_cnt == (mid - EDGE_ONE)) ||
                        (edge_cnt == mid) ||
                        (edge_cnt == (mid + EDGE_ONE));
      hit_last_sample = (edge_cnt == (mid + EDGE_ONE));
   end
`else
   always_comb begin
      hit_sample      = (edge_cnt == mid);
      hit_last_sample = (edge_cnt == mid);
   end
`endif

   // Frame sequencer: state, counters and the captured prescale/frame length.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
         p_reg    <= '0;
         f_reg    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               edge_cnt <= '0;
               bit_cnt  <= '0;
               if (ENABLE) begin
                  p_reg <= p_clamped;
                  f_reg <= f_clamped;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!ENABLE) begin
                  edge_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_IDLE;
               end else if (!edge_last) begin
                  edge_cnt <= edge_cnt + EDGE_ONE;
               end else if (!bit_last) begin
                  edge_cnt <= '0;
                  bit_cnt  <= bit_cnt + BIT_ONE;
               end else begin
                  edge_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               edge_cnt <= '0;
               bit_cnt  <= '0;
               if (!ENABLE) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               edge_cnt <= '0;
               bit_cnt  <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   // Drive the outputs from registered state only, and gate the strobes to RUN.
   always_comb begin
      EDGE_CNT    = edge_cnt;
      BIT_CNT     = bit_cnt;
      BUSY        = in_run;
      SAMPLE_STB  = in_run && hit_sample;
      SAMPLE_LAST = in_run && hit_last_sample;
      BIT_DONE    = in_run && edge_last;
      FRAME_DONE  = in_run && edge_last && bit_last;
   end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed testbench for uart_rx_frame_timer.
// Each RUN cycle packs the observable outputs into one vector and compares it
// with the expected edge/bit position inside the frame. The bench also checks
// frame-done timing and strobe counts against hand-computed constants.

module tb_uart_rx_frame_timer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       ENABLE;
   logic [5:0] PRESCALE;
   logic [3:0] FRAME_BITS;
   logic [5:0] EDGE_CNT;
   logic [3:0] BIT_CNT;
   logic       SAMPLE_STB;
   logic       SAMPLE_LAST;
   logic       BIT_DONE;
   logic       FRAME_DONE;
   logic       BUSY;

   int n_checks = 0;
   int n_pass   = 0;
   int fd_idx;
   int fd_cnt;
   int stb_cnt;

   uart_rx_frame_timer #(.EDGE_W(6), .BIT_W(4)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .ENABLE      (ENABLE),
      .PRESCALE    (PRESCALE),
      .FRAME_BITS  (FRAME_BITS),
      .EDGE_CNT    (EDGE_CNT),
      .BIT_CNT     (BIT_CNT),
      .SAMPLE_STB  (SAMPLE_STB),
      .SAMPLE_LAST (SAMPLE_LAST),
      .BIT_DONE    (BIT_DONE),
      .FRAME_DONE  (FRAME_DONE),
      .BUSY        (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] obs_vec();
      return {17'd0, EDGE_CNT, BIT_CNT, SAMPLE_STB, SAMPLE_LAST, BIT_DONE, FRAME_DONE, BUSY};
   endfunction

   // Expected outputs for RUN cycle index i (0-based) of a frame with captured p, f.
   function automatic logic [31:0] exp_vec(input int p, input int f, input int i);
      int   e = i % p;
      int   b = i / p;
      int   m = p >> 1;
      logic stb, last, bd, fd;
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      stb  = (e >= m - 1) && (e <= m + 1);
      last = (e == m + 1);
`else
      stb  = (e == m);
      last = (e == m);
`endif
      bd = (e == p - 1);
      fd = bd && (b == f - 1);
      return {17'd0, 6'(e), 4'(b), stb, last, bd, fd, 1'b1};
   endfunction

   // Check n RUN cycles starting at frame index start, advancing one clock after each.
   task automatic run_cycles(input int p, input int f, input int start, input int n);
      for (int i = start; i < start + n; i++) begin
         check($sformatf("p%0d_f%0d_cyc%0d", p, f, i), obs_vec(), exp_vec(p, f, i));
         if (FRAME_DONE) begin
            fd_idx = i;
            fd_cnt++;
         end
         if (SAMPLE_STB) stb_cnt++;
         tick();
      end
   endtask

   task automatic clr_stats();
      fd_idx  = -1;
      fd_cnt  = 0;
      stb_cnt = 0;
   endtask

   initial begin
      RST        = 1'b1;
      ENABLE     = 1'b1;
      PRESCALE   = 6'd8;
      FRAME_BITS = 4'd10;
      tick();
      tick();
      check("reset_outputs", obs_vec(), 32'd0);

      // Frame A: P=8, F=10. PRESCALE changes to 16 mid-frame and must be ignored.
      RST = 1'b0;
      check("idle_after_reset", obs_vec(), 32'd0);
      tick();
      clr_stats();
      run_cycles(8, 10, 0, 20);
      PRESCALE = 6'd16;
      run_cycles(8, 10, 20, 60);
      check("a_fd_cycle", 32'(fd_idx + 1), 32'd80);
      check("a_fd_count", 32'(fd_cnt), 32'd1);
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      check("a_stb_count", 32'(stb_cnt), 32'd30);
`else
      check("a_stb_count", 32'(stb_cnt), 32'd10);
`endif
      check("a_done", obs_vec(), 32'd0);
      tick();
      tick();
      check("a_done_hold", obs_vec(), 32'd0);
      ENABLE = 1'b0;
      tick();
      check("a_idle", obs_vec(), 32'd0);

      // Frame B: P=16, F=11.
      ENABLE = 1'b1;
      PRESCALE = 6'd16;
      FRAME_BITS = 4'd11;
      tick();
      clr_stats();
      run_cycles(16, 11, 0, 176);
      check("b_fd_cycle", 32'(fd_idx + 1), 32'd176);
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      check("b_stb_count", 32'(stb_cnt), 32'd33);
`else
      check("b_stb_count", 32'(stb_cnt), 32'd11);
`endif
      check("b_done", obs_vec(), 32'd0);
      ENABLE = 1'b0;
      tick();

      // Frame C: PRESCALE=2, FRAME_BITS=1 clamp to P=4, F=2.
      ENABLE = 1'b1;
      PRESCALE = 6'd2;
      FRAME_BITS = 4'd1;
      tick();
      clr_stats();
      run_cycles(4, 2, 0, 8);
      check("c_fd_cycle", 32'(fd_idx + 1), 32'd8);
`ifdef UART_RX_TRIPLE_SAMPLE_EN
      check("c_stb_count", 32'(stb_cnt), 32'd6);
`else
      check("c_stb_count", 32'(stb_cnt), 32'd2);
`endif
      check("c_done", obs_vec(), 32'd0);
      ENABLE = 1'b0;
      tick();

      // Frame D: abort at BIT_CNT=4, EDGE_CNT=5, then restart from 0.
      ENABLE = 1'b1;
      PRESCALE = 6'd8;
      FRAME_BITS = 4'd10;
      tick();
      clr_stats();
      run_cycles(8, 10, 0, 37);
      check("d_abort_pos", {26'd0, EDGE_CNT}, 32'd5);
      ENABLE = 1'b0;
      run_cycles(8, 10, 37, 1);
      check("d_abort_idle", obs_vec(), 32'd0);
      check("d_no_fd", 32'(fd_cnt), 32'd0);
      ENABLE = 1'b1;
      tick();
      run_cycles(8, 10, 0, 48);
      check("e_pre_rst_bit", {28'd0, BIT_CNT}, 32'd6);

      // Reset mid-frame with ENABLE held high.
      RST = 1'b1;
      tick();
      check("e_rst_outputs", obs_vec(), 32'd0);
      RST = 1'b0;
      check("e_rst_idle", obs_vec(), 32'd0);
      tick();
      run_cycles(8, 10, 0, 3);
      ENABLE = 1'b0;
      tick();
      check("e_final_idle", obs_vec(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_timer.md
# uart_rx_frame_timer

Parametrised oversampling timer for the UART receive path: counts clock edges within each bit and bits within each frame, and produces bit-centre sample strobes, bit-done and frame-done pulses for the RX FSM and data sampler. Prescale and frame length are runtime inputs captured per frame. A terminal DONE state prevents runaway re-counting. Sits between the RX control FSM (drives ENABLE) and the sampler/deserialiser (consumes strobes).

## Interface

- EDGE_W, 6, width of PRESCALE and EDGE_CNT (max prescale 2^EDGE_W-1)
- BIT_W, 4, width of FRAME_BITS and BIT_CNT (max frame 2^BIT_W-1 bits)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- ENABLE  in  1  level; high starts/continues a frame, low aborts/returns to IDLE
- PRESCALE  in  EDGE_W  clock edges per bit; legal 4..2^EDGE_W-1
- FRAME_BITS  in  BIT_W  bits per frame incl. start/parity/stop; legal 2..2^BIT_W-1
- EDGE_CNT  out  EDGE_W  edge index within current bit, 0..P-1
- BIT_CNT  out  BIT_W  bit index within frame, 0..F-1
- SAMPLE_STB  out  1  sample-now strobe
- SAMPLE_LAST  out  1  last sample strobe of the bit (vote resolvable)
- BIT_DONE  out  1  high on last edge of every bit
- FRAME_DONE  out  1  high on last edge of last bit
- BUSY  out  1  high while in RUN

## Operation

- States: IDLE, RUN, DONE. Registered state, EDGE_CNT, BIT_CNT, captured P, F.
- IDLE: counters 0, BUSY 0. ENABLE=1 → capture P←PRESCALE, F←FRAME_BITS, EDGE_CNT←0, BIT_CNT←0, go RUN.
- Capture clamps: PRESCALE<4 → P=4; FRAME_BITS<2 → F=2. PRESCALE/FRAME_BITS changes during RUN ignored.
- RUN, ENABLE=0: go IDLE, counters←0 (abort; no BIT_DONE/FRAME_DONE).
- RUN, ENABLE=1, EDGE_CNT≠P-1: EDGE_CNT+1.
- RUN, ENABLE=1, EDGE_CNT=P-1, BIT_CNT≠F-1: EDGE_CNT←0, BIT_CNT+1.
- RUN, ENABLE=1, EDGE_CNT=P-1, BIT_CNT=F-1: counters←0, go DONE.
- DONE: counters 0, BUSY 0; stays until ENABLE=0, then IDLE. New frame needs ENABLE low for ≥1 cycle.
- Mid point M = P>>1 (floor). Strobes decode registered state/counters only (no input-to-output path), valid only in RUN:
  - SAMPLE_STB at EDGE_CNT ∈ sample set (see Configuration); SAMPLE_LAST at highest member.
  - BIT_DONE at EDGE_CNT=P-1; FRAME_DONE = BIT_DONE && BIT_CNT=F-1.
- All comparisons at EDGE_W / BIT_W width; P-1 never underflows due to clamp; counters never wrap past P-1/F-1.

## Timing

- RST=1 at a clock edge: state IDLE, EDGE_CNT=0, BIT_CNT=0, all strobes 0, BUSY 0, P/F registers 0; overrides ENABLE, including mid-frame.
- ENABLE high in IDLE → first RUN cycle (EDGE_CNT=0, BUSY=1) one cycle later.
- Frame occupies exactly P·F RUN cycles; FRAME_DONE in the P·F-th RUN cycle; DONE in the following cycle.
- ENABLE low in RUN → IDLE next cycle; strobes already decoded for the current cycle still show.
- Strobes are single-cycle; SAMPLE_STB/BIT_DONE never coincide since M+1 ≤ P-2 for P≥5; at P=4 SAMPLE_LAST (edge 3) coincides with BIT_DONE — permitted.

## Configuration

- UART_RX_TRIPLE_SAMPLE_EN defined: sample set {M-1, M, M+1}; three SAMPLE_STB pulses per bit, SAMPLE_LAST at M+1 (majority-vote sampling).
- Undefined: sample set {M}; one SAMPLE_STB per bit, SAMPLE_LAST coincident with it at M.

## Test plan

- Triple-sample on, PRESCALE=8, FRAME_BITS=10, ENABLE held: SAMPLE_STB at EDGE_CNT 3,4,5, SAMPLE_LAST at 5, BIT_DONE at 7 per bit; FRAME_DONE in RUN cycle 80 with BIT_CNT=9; then DONE, BUSY 0, no restart until ENABLE toggles.
- Macro off, PRESCALE=16, FRAME_BITS=11: one SAMPLE_STB at EDGE_CNT 8, SAMPLE_LAST same cycle; FRAME_DONE at RUN cycle 176.
- PRESCALE=2, FRAME_BITS=1 → clamped P=4, F=2: FRAME_DONE at RUN cycle 8; triple-sample strobes at 1,2,3, BIT_DONE at 3.
- ENABLE dropped at BIT_CNT=4, EDGE_CNT=5 (P=8): IDLE next cycle, counters 0, no FRAME_DONE; re-raise → fresh frame from 0.
- RST=1 mid-frame (BIT_CNT=6) with ENABLE high: all outputs 0 next cycle; after RST low, RUN one cycle later.
- PRESCALE changed 8→16 mid-frame: bit length stays 8 until next frame capture.
